spi_master_full_duplex: RTL and testbench

//  Parametrised full-duplex SPI master. Next generation of the 12-bit, mode-0, transmit-only master.

---
 rtl/spi_pkg.sv | 32 +++
 rtl/spi_sclk_gen.sv | 44 ++++
 rtl/spi_master_full_duplex.sv | 195 +++++++++++++++++++
 tb/tb_spi_master_full_duplex.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types for the SPI master: FSM state encoding, SPI mode encoding and mode decode helper.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      XFER  = 3'd2,
      HOLD  = 3'd3,
      GAP   = 3'd4
   } spi_state_e;

   typedef enum logic [1:0] {
      MODE0 = 2'd0,
      MODE1 = 2'd1,
      MODE2 = 2'd2,
      MODE3 = 2'd3
   } spi_mode_e;

   // Returns {cpol, cpha} for a standard SPI mode number.
   function automatic logic [1:0] mode_to_cpol_cpha(input spi_mode_e mode);
      logic [1:0] r;
      case (mode)
         MODE0:   r = 2'b00;
         MODE1:   r = 2'b01;
         MODE2:   r = 2'b10;
         MODE3:   r = 2'b11;
         default: r = 2'b00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI serial clock generator: free-running divider while enabled, registered sclk and
// one-cycle lead/trail strobes that announce the sclk edge taken on the next clk edge.
module spi_sclk_gen #(
   parameter int   CLK_DIV = 10,
   parameter logic CPOL    = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic tgl_en,
   output logic tick,
   output logic sclk,
   output logic lead_stb,
   output logic trail_stb
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt;

   // The divider sits at zero while disabled, so the first tick lands CLK_DIV cycles after enable.
   assign tick      = en && (cnt == CW'(CLK_DIV - 1));
   assign lead_stb  = tick && tgl_en && (sclk == CPOL);
   assign trail_stb = tick && tgl_en && (sclk != CPOL);

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         sclk <= CPOL;
      end else if (tick && tgl_en) begin
         sclk <= ~sclk;
      end
   end

endmodule

// File: rtl/spi_master_full_duplex.sv
// Parametrised full-duplex SPI master (FSM, tx/rx shift registers, sclk edge counter).
// Optional SPI_MASTER_LOOPBACK_EN adds loop_en, feeding internal mosi into the rx shifter.
module spi_master_full_duplex
   import spi_pkg::*;
#(
   parameter int DW        = 12,
   parameter int CLK_DIV   = 10,
   parameter int CPOL      = 0,
   parameter int CPHA      = 0,
   parameter int LSB_FIRST = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tx_valid,
   output logic          tx_ready,
   input  logic [DW-1:0] tx_data,
   output logic          rx_valid,
   output logic [DW-1:0] rx_data,
   output logic          busy,
   output logic          cs_n,
   output logic          sclk,
   output logic          mosi,
   input  logic          miso,
`ifdef SPI_MASTER_LOOPBACK_EN
   input  logic          loop_en,
`endif
   output spi_state_e    state_dbg
);

   if (DW < 1 || CLK_DIV < 2) begin : g_param_check
      $error("spi_master_full_duplex: DW must be >= 1 and CLK_DIV must be >= 2");
   end

   localparam logic CPOL_L = (CPOL != 0);
   localparam logic CPHA_L = (CPHA != 0);
   localparam logic LSB_L  = (LSB_FIRST != 0);
   localparam int   BCW    = $clog2(2 * DW + 1);
   localparam logic [BCW-1:0] LAST_EDGE = BCW'(2 * DW);
   localparam logic [BCW-1:0] PEN_EDGE  = BCW'(2 * DW - 1);

   spi_state_e     state, state_nxt;
   logic [BCW-1:0] edge_cnt;
   logic [DW-1:0]  tx_sh, rx_sh, rx_nxt;
   logic           hs, gen_en, gen_tgl, done;
   logic           tick, lead_stb, trail_stb;
   logic           sample_stb, shift_stb, rx_din;

   // Handshake: a word is accepted at the clk edge where tx_valid && tx_ready. tx_valid is
   // ignored while busy and must be held by the source; rx_valid is a 1-cycle pulse, no backpressure.
   assign tx_ready  = (state == IDLE) && !rst;
   assign hs        = tx_valid && tx_ready;
   assign busy      = (state != IDLE);
   assign state_dbg = state;

   function automatic logic first_bit(input logic [DW-1:0] w);
      return LSB_L ? w[0] : w[DW-1];
   endfunction

   function automatic logic [DW-1:0] shift_word(input logic [DW-1:0] w);
      return LSB_L ? (w >> 1) : (w << 1);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      gen_en    = 1'b0;
      gen_tgl   = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (tx_valid) state_nxt = SETUP;
         end
         SETUP: begin
            gen_en = 1'b1;
            if (tick) state_nxt = XFER;
         end
         XFER: begin
            gen_en  = 1'b1;
            gen_tgl = (edge_cnt != LAST_EDGE);
            // After the last edge XFER still waits one full half-period before HOLD.
            if (tick && (edge_cnt == LAST_EDGE)) state_nxt = HOLD;
         end
         HOLD: begin
            gen_en = 1'b1;
            if (tick) begin
               done      = 1'b1;
               state_nxt = GAP;
            end
         end
         GAP: begin
            gen_en = 1'b1;
            if (tick) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   spi_sclk_gen #(
      .CLK_DIV (CLK_DIV),
      .CPOL    (CPOL_L)
   ) u_sclk_gen (
      .clk       (clk),
      .rst       (rst),
      .en        (gen_en),
      .tgl_en    (gen_tgl),
      .tick      (tick),
      .sclk      (sclk),
      .lead_stb  (lead_stb),
      .trail_stb (trail_stb)
   );

   // CPHA=0 presents bit 0 at the handshake, so the final trailing edge has nothing left to shift.
   assign sample_stb = CPHA_L ? trail_stb : lead_stb;
   assign shift_stb  = CPHA_L ? lead_stb  : (trail_stb && (edge_cnt != PEN_EDGE));

`ifdef SPI_MASTER_LOOPBACK_EN
   logic loop_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         loop_q <= 1'b0;
      end else if (hs) begin
         loop_q <= loop_en;
      end
   end

   assign rx_din = loop_q ? mosi : miso;
`else
   assign rx_din = miso;
`endif

   always_comb begin
      rx_nxt = rx_sh;
      if (LSB_L) begin
         rx_nxt         = rx_sh >> 1;
         rx_nxt[DW-1]   = rx_din;
      end else begin
         rx_nxt         = rx_sh << 1;
         rx_nxt[0]      = rx_din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || hs) begin
         edge_cnt <= '0;
      end else if (tick && gen_tgl) begin
         edge_cnt <= edge_cnt + BCW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_sh    <= '0;
         rx_sh    <= '0;
         mosi     <= 1'b0;
         cs_n     <= 1'b1;
         rx_valid <= 1'b0;
         rx_data  <= '0;
      end else begin
         rx_valid <= 1'b0;
         if (hs) begin
            cs_n  <= 1'b0;
            rx_sh <= '0;
            if (CPHA_L) begin
               tx_sh <= tx_data;
            end else begin
               tx_sh <= shift_word(tx_data);
               mosi  <= first_bit(tx_data);
            end
         end else begin
            if (shift_stb) begin
               mosi  <= first_bit(tx_sh);
               tx_sh <= shift_word(tx_sh);
            end
            if (sample_stb) begin
               rx_sh <= rx_nxt;
            end
            if (done) begin
               cs_n     <= 1'b1;
               mosi     <= 1'b0;
               rx_valid <= 1'b1;
               rx_data  <= rx_sh;
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_master_full_duplex.sv
// Bench for spi_master_full_duplex: a mode-0 LSB-first instance and a mode-3 MSB-first instance,
// each talking to a behavioural SPI slave that records mosi words and drives miso from a queue.
`timescale 1ns/1ps
module tb_spi_master_full_duplex;
   import spi_pkg::*;

   localparam int DW_A = 12, DIV_A = 10, CPOL_A = 0, CPHA_A = 0, LSB_A = 1;
   localparam logic [1:0] M3 = mode_to_cpol_cpha(MODE3);
   localparam int DW_B = 8, DIV_B = 4, LSB_B = 0;
   localparam int CPOL_B = int'(M3[1]);
   localparam int CPHA_B = int'(M3[0]);
   localparam int TMO = 2000;

   int n_vec = 0;
   int n_err = 0;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic            tx_valid_a = 1'b0, tx_ready_a, rx_valid_a, busy_a, cs_n_a, sclk_a, mosi_a;
   logic            miso_a = 1'b0;
   logic [DW_A-1:0] tx_data_a = '0, rx_data_a;
   spi_state_e      state_a;
   logic            tx_valid_b = 1'b0, tx_ready_b, rx_valid_b, busy_b, cs_n_b, sclk_b, mosi_b;
   logic            miso_b = 1'b0;
   logic [DW_B-1:0] tx_data_b = '0, rx_data_b;
   spi_state_e      state_b;
`ifdef SPI_MASTER_LOOPBACK_EN
   logic            loop_en_a = 1'b0;
   logic            loop_en_b = 1'b0;
`endif

   spi_master_full_duplex #(.DW(DW_A), .CLK_DIV(DIV_A), .CPOL(CPOL_A), .CPHA(CPHA_A), .LSB_FIRST(LSB_A)) dut_a (
      .clk(clk), .rst(rst), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .tx_data(tx_data_a),
      .rx_valid(rx_valid_a), .rx_data(rx_data_a), .busy(busy_a), .cs_n(cs_n_a), .sclk(sclk_a),
      .mosi(mosi_a), .miso(miso_a),
`ifdef SPI_MASTER_LOOPBACK_EN
      .loop_en(loop_en_a),
`endif
      .state_dbg(state_a));

   spi_master_full_duplex #(.DW(DW_B), .CLK_DIV(DIV_B), .CPOL(CPOL_B), .CPHA(CPHA_B), .LSB_FIRST(LSB_B)) dut_b (
      .clk(clk), .rst(rst), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .tx_data(tx_data_b),
      .rx_valid(rx_valid_b), .rx_data(rx_data_b), .busy(busy_b), .cs_n(cs_n_b), .sclk(sclk_b),
      .mosi(mosi_b), .miso(miso_b),
`ifdef SPI_MASTER_LOOPBACK_EN
      .loop_en(loop_en_b),
`endif
      .state_dbg(state_b));

   // Behavioural slave + recorder for instance A (sampled on the falling clk edge).
   logic [DW_A-1:0] slv_q_a[$], got_rx_a[$], got_mosi_a[$];
   int              hs_a[$], cs_rise_a[$];
   logic [DW_A-1:0] slv_a = '0, cap_a = '0;
   int              cyc_a = 0, sb_a = 0, cap_n_a = 0, edges_a = 0, rxv_long_a = 0;
   logic            cs_d_a = 1'b1, sclk_d_a = 1'b0, rxv_d_a = 1'b0;

   always @(negedge clk) begin
      cyc_a++;
      if (tx_valid_a && tx_ready_a) hs_a.push_back(cyc_a);
      if (rx_valid_a) got_rx_a.push_back(rx_data_a);
      if (rx_valid_a && rxv_d_a) rxv_long_a++;
      if (!cs_d_a && cs_n_a) begin
         cs_rise_a.push_back(cyc_a);
         got_mosi_a.push_back(cap_a);
      end
      if (cs_d_a && !cs_n_a) begin
         slv_a   = (slv_q_a.size() != 0) ? slv_q_a.pop_front() : '0;
         sb_a    = 0;
         cap_a   = '0;
         cap_n_a = 0;
         edges_a = 0;
         if (CPHA_A == 0) begin
            miso_a = LSB_A ? slv_a[0] : slv_a[DW_A-1];
            sb_a   = 1;
         end
      end else if (!cs_n_a && (sclk_a !== sclk_d_a)) begin
         edges_a++;
         if ((sclk_a != CPOL_A) == (CPHA_A == 0)) begin
            if (cap_n_a < DW_A) cap_a[LSB_A ? cap_n_a : DW_A-1-cap_n_a] = mosi_a;
            cap_n_a++;
         end else if (sb_a < DW_A) begin
            miso_a = slv_a[LSB_A ? sb_a : DW_A-1-sb_a];
            sb_a++;
         end
      end
      cs_d_a   = cs_n_a;
      sclk_d_a = sclk_a;
      rxv_d_a  = rx_valid_a;
   end

   // Behavioural slave + recorder for instance B.
   logic [DW_B-1:0] slv_q_b[$], got_rx_b[$], got_mosi_b[$];
   int              hs_b[$], cs_rise_b[$];
   logic [DW_B-1:0] slv_b = '0, cap_b = '0;
   int              cyc_b = 0, sb_b = 0, cap_n_b = 0, edges_b = 0, rxv_long_b = 0;
   logic            cs_d_b = 1'b1, sclk_d_b = 1'b1, rxv_d_b = 1'b0;

   always @(negedge clk) begin
      cyc_b++;
      if (tx_valid_b && tx_ready_b) hs_b.push_back(cyc_b);
      if (rx_valid_b) got_rx_b.push_back(rx_data_b);
      if (rx_valid_b && rxv_d_b) rxv_long_b++;
      if (!cs_d_b && cs_n_b) begin
         cs_rise_b.push_back(cyc_b);
         got_mosi_b.push_back(cap_b);
      end
      if (cs_d_b && !cs_n_b) begin
         slv_b   = (slv_q_b.size() != 0) ? slv_q_b.pop_front() : '0;
         sb_b    = 0;
         cap_b   = '0;
         cap_n_b = 0;
         edges_b = 0;
         if (CPHA_B == 0) begin
            miso_b = LSB_B ? slv_b[0] : slv_b[DW_B-1];
            sb_b   = 1;
         end
      end else if (!cs_n_b && (sclk_b !== sclk_d_b)) begin
         edges_b++;
         if ((sclk_b != CPOL_B) == (CPHA_B == 0)) begin
            if (cap_n_b < DW_B) cap_b[LSB_B ? cap_n_b : DW_B-1-cap_n_b] = mosi_b;
            cap_n_b++;
         end else if (sb_b < DW_B) begin
            miso_b = slv_b[LSB_B ? sb_b : DW_B-1-sb_b];
            sb_b++;
         end
      end
      cs_d_b   = cs_n_b;
      sclk_d_b = sclk_b;
      rxv_d_b  = rx_valid_b;
   end

   // driver tasks
   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_a();
      hs_a.delete(); cs_rise_a.delete(); got_rx_a.delete(); got_mosi_a.delete(); slv_q_a.delete();
      rxv_long_a = 0;
   endtask

   task automatic clear_b();
      hs_b.delete(); cs_rise_b.delete(); got_rx_b.delete(); got_mosi_b.delete(); slv_q_b.delete();
      rxv_long_b = 0;
   endtask

   task automatic start_a(input logic [DW_A-1:0] tx, input logic [DW_A-1:0] slv);
      int n;
      slv_q_a.push_back(slv);
      tx_data_a  = tx;
      tx_valid_a = 1'b1;
      n = 0;
      do begin
         step();
         n++;
      end while (!busy_a && n < TMO);
      tx_valid_a = 1'b0;
      if (!busy_a) begin
         n_vec++; n_err++;
         $display("FAIL start_a: handshake not taken within %0d cycles", TMO);
      end
   endtask

   task automatic finish_a();
      int n = 0;
      while (!tx_ready_a && n < TMO) begin
         step();
         n++;
      end
      if (!tx_ready_a) begin
         n_vec++; n_err++;
         $display("FAIL finish_a: tx_ready not back within %0d cycles", TMO);
      end
   endtask

   task automatic start_b(input logic [DW_B-1:0] tx, input logic [DW_B-1:0] slv);
      int n;
      slv_q_b.push_back(slv);
      tx_data_b  = tx;
      tx_valid_b = 1'b1;
      n = 0;
      do begin
         step();
         n++;
      end while (!busy_b && n < TMO);
      tx_valid_b = 1'b0;
      if (!busy_b) begin
         n_vec++; n_err++;
         $display("FAIL start_b: handshake not taken within %0d cycles", TMO);
      end
   endtask

   task automatic finish_b();
      int n = 0;
      while (!tx_ready_b && n < TMO) begin
         step();
         n++;
      end
      if (!tx_ready_b) begin
         n_vec++; n_err++;
         $display("FAIL finish_b: tx_ready not back within %0d cycles", TMO);
      end
   endtask

   // tests
   task automatic test_reset();
      rst = 1'b1;
      step(3);
      n_vec++; if (cs_n_a !== 1'b1)   begin n_err++; $display("FAIL rst_cs_n: got %b want 1", cs_n_a); end
      n_vec++; if (sclk_a !== 1'b0)   begin n_err++; $display("FAIL rst_sclk_a: got %b want 0", sclk_a); end
      n_vec++; if (sclk_b !== 1'b1)   begin n_err++; $display("FAIL rst_sclk_b: got %b want 1", sclk_b); end
      n_vec++; if (mosi_a !== 1'b0)   begin n_err++; $display("FAIL rst_mosi: got %b want 0", mosi_a); end
      n_vec++; if (rx_valid_a !== 1'b0) begin n_err++; $display("FAIL rst_rx_valid: got %b want 0", rx_valid_a); end
      n_vec++; if (rx_data_a !== '0)  begin n_err++; $display("FAIL rst_rx_data: got %h want 0", rx_data_a); end
      n_vec++; if (busy_a !== 1'b0)   begin n_err++; $display("FAIL rst_busy: got %b want 0", busy_a); end
      n_vec++; if (tx_ready_a !== 1'b0) begin n_err++; $display("FAIL rst_tx_ready: got %b want 0", tx_ready_a); end
      n_vec++; if (state_a !== IDLE)  begin n_err++; $display("FAIL rst_state: got %0d want IDLE", state_a); end
      rst = 1'b0;
      step();
      n_vec++; if (tx_ready_a !== 1'b1) begin n_err++; $display("FAIL post_rst_tx_ready: got %b want 1", tx_ready_a); end
   endtask

   task automatic test_mode0();
      clear_a();
      start_a(12'hA5C, 12'h3C1);
      n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL m0_busy: got %b want 1", busy_a); end
      finish_a();
      step(20);
      n_vec++; if (got_rx_a.size() != 1) begin n_err++; $display("FAIL m0_rx_count: got %0d want 1", got_rx_a.size()); end
      else begin n_vec++; if (got_rx_a[0] !== 12'h3C1) begin n_err++; $display("FAIL m0_rx_data: got %h want 3c1", got_rx_a[0]); end end
      n_vec++; if (rx_data_a !== 12'h3C1) begin n_err++; $display("FAIL m0_rx_hold: got %h want 3c1", rx_data_a); end
      n_vec++; if (got_mosi_a.size() != 1 || got_mosi_a[0] !== 12'hA5C) begin n_err++; $display("FAIL m0_mosi: got %h want a5c", (got_mosi_a.size() != 0) ? got_mosi_a[0] : 12'h0); end
      n_vec++; if (edges_a != 2*DW_A) begin n_err++; $display("FAIL m0_edges: got %0d want %0d", edges_a, 2*DW_A); end
      n_vec++; if (hs_a.size() != 1 || cs_rise_a.size() != 1 || cs_rise_a[0] - hs_a[0] - 1 != DIV_A*(2*DW_A+3)) begin
         n_err++; $display("FAIL m0_cs_rise_cycle: got %0d want %0d", (cs_rise_a.size() != 0 && hs_a.size() != 0) ? cs_rise_a[0] - hs_a[0] - 1 : -1, DIV_A*(2*DW_A+3));
      end
      n_vec++; if (sclk_a !== 1'b0) begin n_err++; $display("FAIL m0_sclk_end: got %b want 0", sclk_a); end
      n_vec++; if (rxv_long_a != 0) begin n_err++; $display("FAIL m0_rx_valid_width: got %0d long pulses want 0", rxv_long_a); end
   endtask

   task automatic test_mode3();
      clear_b();
      n_vec++; if (sclk_b !== 1'b1) begin n_err++; $display("FAIL m3_sclk_idle: got %b want 1", sclk_b); end
      start_b(8'h81, 8'h7E);
      finish_b();
      step(5);
      n_vec++; if (got_rx_b.size() != 1 || got_rx_b[0] !== 8'h7E) begin n_err++; $display("FAIL m3_rx_data: got %h want 7e", rx_data_b); end
      n_vec++; if (got_mosi_b.size() != 1 || got_mosi_b[0] !== 8'h81) begin n_err++; $display("FAIL m3_mosi: got %h want 81", (got_mosi_b.size() != 0) ? got_mosi_b[0] : 8'h0); end
      n_vec++; if (edges_b != 2*DW_B) begin n_err++; $display("FAIL m3_edges: got %0d want %0d", edges_b, 2*DW_B); end
      n_vec++; if (hs_b.size() != 1 || cs_rise_b.size() != 1 || cs_rise_b[0] - hs_b[0] - 1 != DIV_B*(2*DW_B+3)) begin
         n_err++; $display("FAIL m3_cs_rise_cycle: want %0d", DIV_B*(2*DW_B+3));
      end
      n_vec++; if (sclk_b !== 1'b1) begin n_err++; $display("FAIL m3_sclk_end: got %b want 1", sclk_b); end
   endtask

   task automatic test_back_to_back();
      logic [DW_A-1:0] s0, s1;
      int n;
      clear_a();
      s0 = DW_A'($urandom);
      s1 = DW_A'($urandom);
      slv_q_a.push_back(s0);
      slv_q_a.push_back(s1);
      tx_data_a  = 12'h001;
      tx_valid_a = 1'b1;
      n = 0;
      do begin step(); n++; end while (!busy_a && n < TMO);
      tx_data_a = 12'h800;
      n = 0;
      while (hs_a.size() < 2 && n < TMO) begin step(); n++; end
      tx_valid_a = 1'b0;
      finish_a();
      step(3);
      n_vec++; if (hs_a.size() != 2 || cs_rise_a.size() < 1 || hs_a[1] - cs_rise_a[0] != DIV_A) begin
         n_err++; $display("FAIL b2b_gap: got %0d want %0d", (hs_a.size() == 2 && cs_rise_a.size() != 0) ? hs_a[1] - cs_rise_a[0] : -1, DIV_A);
      end
      n_vec++; if (got_rx_a.size() != 2) begin n_err++; $display("FAIL b2b_rx_count: got %0d want 2", got_rx_a.size()); end
      else begin
         n_vec++; if (got_rx_a[0] !== s0 || got_rx_a[1] !== s1) begin n_err++; $display("FAIL b2b_rx_data: got %h %h want %h %h", got_rx_a[0], got_rx_a[1], s0, s1); end
      end
      n_vec++; if (got_mosi_a.size() != 2 || got_mosi_a[0] !== 12'h001 || got_mosi_a[1] !== 12'h800) begin
         n_err++; $display("FAIL b2b_mosi: got %0d words want 001 800", got_mosi_a.size());
      end
   endtask

   task automatic test_ignore_while_busy();
      logic [DW_A-1:0] tx, slv;
      clear_a();
      tx  = DW_A'($urandom);
      slv = DW_A'($urandom);
      start_a(tx, slv);
      step(4*DIV_A);
      tx_data_a  = ~tx;
      tx_valid_a = 1'b1;
      step(5*DIV_A);
      tx_valid_a = 1'b0;
      finish_a();
      step(2);
      n_vec++; if (hs_a.size() != 1) begin n_err++; $display("FAIL ign_handshakes: got %0d want 1", hs_a.size()); end
      n_vec++; if (got_mosi_a.size() != 1 || got_mosi_a[0] !== tx) begin n_err++; $display("FAIL ign_mosi: want %h", tx); end
      n_vec++; if (got_rx_a.size() != 1 || got_rx_a[0] !== slv) begin n_err++; $display("FAIL ign_rx: got %h want %h", rx_data_a, slv); end
   endtask

   task automatic test_reset_mid_frame();
      int n;
      clear_a();
      start_a(DW_A'($urandom), DW_A'($urandom) | 12'h001);
      n = 0;
      while (cap_n_a < 5 && n < TMO) begin step(); n++; end
      rst = 1'b1;
      step();
      n_vec++; if (cs_n_a !== 1'b1) begin n_err++; $display("FAIL mid_rst_cs_n: got %b want 1", cs_n_a); end
      n_vec++; if (sclk_a !== 1'b0) begin n_err++; $display("FAIL mid_rst_sclk: got %b want 0", sclk_a); end
      n_vec++; if (rx_data_a !== '0) begin n_err++; $display("FAIL mid_rst_rx_data: got %h want 0", rx_data_a); end
      n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", busy_a); end
      rst = 1'b0;
      step();
      n_vec++; if (tx_ready_a !== 1'b1) begin n_err++; $display("FAIL mid_rst_tx_ready: got %b want 1", tx_ready_a); end
      step(DIV_A*(2*DW_A+6));
      n_vec++; if (got_rx_a.size() != 0) begin n_err++; $display("FAIL mid_rst_rx_valid: got %0d pulses want 0", got_rx_a.size()); end
   endtask

   task automatic test_random();
      logic [DW_A-1:0] ta, sa;
      logic [DW_B-1:0] tb, sb;
      for (int i = 0; i < 4; i++) begin
         clear_a();
         clear_b();
         ta = DW_A'($urandom); sa = DW_A'($urandom);
         tb = DW_B'($urandom); sb = DW_B'($urandom);
         step($urandom_range(0, 5));
         start_a(ta, sa);
         finish_a();
         start_b(tb, sb);
         finish_b();
         step(2);
         n_vec++; if (got_rx_a.size() != 1 || got_rx_a[0] !== sa) begin n_err++; $display("FAIL rnd_a_rx[%0d]: got %h want %h", i, rx_data_a, sa); end
         n_vec++; if (got_mosi_a.size() != 1 || got_mosi_a[0] !== ta) begin n_err++; $display("FAIL rnd_a_mosi[%0d]: want %h", i, ta); end
         n_vec++; if (got_rx_b.size() != 1 || got_rx_b[0] !== sb) begin n_err++; $display("FAIL rnd_b_rx[%0d]: got %h want %h", i, rx_data_b, sb); end
         n_vec++; if (got_mosi_b.size() != 1 || got_mosi_b[0] !== tb) begin n_err++; $display("FAIL rnd_b_mosi[%0d]: want %h", i, tb); end
      end
   endtask

`ifdef SPI_MASTER_LOOPBACK_EN
   task automatic test_loopback();
      clear_a();
      loop_en_a = 1'b1;
      start_a(12'h5A3, 12'h000);
      loop_en_a = 1'b0;
      finish_a();
      step(2);
      n_vec++; if (got_rx_a.size() != 1 || got_rx_a[0] !== 12'h5A3) begin n_err++; $display("FAIL loopback_rx: got %h want 5a3", rx_data_a); end
   endtask
`endif

   initial begin
      test_reset();
      test_mode0();
      test_mode3();
      test_back_to_back();
      test_ignore_while_busy();
      test_reset_mid_frame();
      test_random();
`ifdef SPI_MASTER_LOOPBACK_EN
      test_loopback();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
